vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single VRAM controller port between three requesters: display scanout (read), renderer
//  read and renderer write. Scanout has fixed top priority; renderer read/write alternate round-robin.
//  Sits between the display/renderer blocks and the VRAM controller. One transaction is outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH       20   VRAM word address width
//  DATA_WIDTH       24   VRAM word width (RGB)
//  WATCHDOG_CYCLES  255  max BUSY cycles before abort (only with VRAM_ARB_WATCHDOG_EN)
// PORTS
//  i_master_clk           in   1    master clock
//  i_reset                in   1    asynchronous reset, active-high
//  i_scan_read_address    in   AW   scanout read address
//  i_scan_read_request    in   1    scanout read request (level)
//  o_scan_read_data       out  DW   read data (shared bus)
//  o_scan_read_data_valid out  1    scanout read completion pulse
//  i_rend_read_address    in   AW   renderer read address
//  i_rend_read_request    in   1    renderer read request (level)
//  o_rend_read_data       out  DW   read data (shared bus)
//  o_rend_read_data_valid out  1    renderer read completion pulse
//  i_rend_write_address   in   AW   renderer write address
//  i_rend_write_data      in   DW   renderer write data
//  i_rend_write_request   in   1    renderer write request (level)
//  o_rend_write_done      out  1    renderer write completion pulse
//  o_vram_address         out  AW   address to VRAM controller
//  o_vram_write_data      out  DW   write data to VRAM controller
//  o_vram_write_enable    out  1    1=write, 0=read
//  o_vram_request         out  1    request to VRAM controller (level)
//  i_vram_read_data       in   DW   read data from controller
//  i_vram_read_data_valid in   1    read completion pulse from controller
//  i_vram_write_done      in   1    write completion pulse from controller
//  o_busy                 out  1    1 while a transaction is in flight
//  o_error                out  1    sticky watchdog abort flag (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: state IDLE, all o_* = 0, round-robin pointer = READ; reset mid-transaction abandons it silently.
//  - Requester rule: hold request+address(+data) stable until own completion pulse; drop or present a new
//    request on the next cycle. Arbiter never de-grants early.
//  - FSM IDLE: if any request, pick winner: scan > (rr==READ ? rend_read : rend_write) > other renderer;
//    register address/data/write_enable, o_vram_request<=1, o_busy<=1, -> BUSY. Grant latency 1 cycle.
//  - FSM BUSY: hold outputs. Completion = i_vram_read_data_valid (read) or i_vram_write_done (write);
//    forward combinationally to winner only (o_*_valid/done = completion & grant) in the same cycle;
//    o_vram_request, o_busy <= 0, -> IDLE. Back-to-back: next grant issued the cycle after completion.
//  - Completion of the wrong type, or while IDLE, is ignored.
//  - rr pointer toggles only when a renderer requester is granted; scan grants leave it unchanged.
//  - o_*_read_data = i_vram_read_data unregistered (valid only with the pulse).
//  - Scanout can starve renderer; display pacing guarantees gaps.
// CONFIGURATION
//  VRAM_ARB_WATCHDOG_EN defined: cycle counter runs in BUSY; on reaching WATCHDOG_CYCLES with no completion,
//   drop o_vram_request, pulse winner's completion (data undefined), set o_error (cleared only by i_reset),
//   -> IDLE. Undefined: no counter, BUSY waits forever, o_error tied 0.
// TESTING
//  - Reset: assert i_reset mid-BUSY -> o_vram_request/o_busy/all pulses 0 immediately; IDLE after release.
//  - Scan+rend_read+rend_write all high at once -> scan granted first (addr=scan), then rend_read, then write.
//  - Rend read and write both held continuously, 6 transactions -> grants alternate R,W,R,W,R,W.
//  - Write 0x00ABCD to 0x12345, controller done after 3 cycles -> o_rend_write_done 1 pulse, next grant +1 cycle.
//  - Read, controller returns 0xFFFFFF valid -> only o_rend_read_data_valid pulses; scan valid stays 0.
//  - WATCHDOG_EN, WATCHDOG_CYCLES=8, no completion -> abort after 8 BUSY cycles, o_error=1 sticky.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout has fixed priority, renderer read/write alternate round-robin.
// Define VRAM_ARB_WATCHDOG_EN to add a BUSY-cycle watchdog that aborts a stuck transaction.
module vram_arbiter #(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 24,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic                  i_master_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_scan_read_address,
    input  logic                  i_scan_read_request,
    output logic [DATA_WIDTH-1:0] o_scan_read_data,
    output logic                  o_scan_read_data_valid,
    input  logic [ADDR_WIDTH-1:0] i_rend_read_address,
    input  logic                  i_rend_read_request,
    output logic [DATA_WIDTH-1:0] o_rend_read_data,
    output logic                  o_rend_read_data_valid,
    input  logic [ADDR_WIDTH-1:0] i_rend_write_address,
    input  logic [DATA_WIDTH-1:0] i_rend_write_data,
    input  logic                  i_rend_write_request,
    output logic                  o_rend_write_done,
    output logic [ADDR_WIDTH-1:0] o_vram_address,
    output logic [DATA_WIDTH-1:0] o_vram_write_data,
    output logic                  o_vram_write_enable,
    output logic                  o_vram_request,
    input  logic [DATA_WIDTH-1:0] i_vram_read_data,
    input  logic                  i_vram_read_data_valid,
    input  logic                  i_vram_write_done,
    output logic                  o_busy,
    output logic                  o_error
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    typedef enum logic [1:0] {G_SCAN, G_READ, G_WRITE} grant_t;

    state_t                r_state;
    grant_t                r_grant;
    logic                  r_rrWrite;
    grant_t                w_pick;
    logic [ADDR_WIDTH-1:0] w_pickAddress;
    logic                  w_anyRequest;
    logic                  w_typeDone;
    logic                  w_timeout;
    logic                  w_finish;

    if (WATCHDOG_CYCLES < 1) begin : g_badWatchdog
        $error("WATCHDOG_CYCLES must be at least 1");
    end

    // The round-robin pointer only names the preferred renderer; the other still wins if it is alone.
    always_comb begin
        w_anyRequest  = i_scan_read_request | i_rend_read_request | i_rend_write_request;
        w_pick        = G_WRITE;
        w_pickAddress = i_rend_write_address;
        if (i_scan_read_request) begin
            w_pick        = G_SCAN;
            w_pickAddress = i_scan_read_address;
        end else if (i_rend_read_request && (!r_rrWrite || !i_rend_write_request)) begin
            w_pick        = G_READ;
            w_pickAddress = i_rend_read_address;
        end
    end

    assign w_typeDone = o_vram_write_enable ? i_vram_write_done : i_vram_read_data_valid;
    assign w_finish   = (r_state == S_BUSY) && (w_typeDone || w_timeout);

    assign o_scan_read_data       = i_vram_read_data;
    assign o_rend_read_data       = i_vram_read_data;
    assign o_scan_read_data_valid = w_finish && (r_grant == G_SCAN);
    assign o_rend_read_data_valid = w_finish && (r_grant == G_READ);
    assign o_rend_write_done      = w_finish && (r_grant == G_WRITE);

`ifdef VRAM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

    logic [CW-1:0] r_wdCount;
    logic          r_error;

    // Count 0 marks the first BUSY cycle, so the abort lands in BUSY cycle WATCHDOG_CYCLES.
    assign w_timeout = (r_state == S_BUSY) && !w_typeDone &&
                       (r_wdCount == CW'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdCount <= '0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == S_BUSY) r_wdCount <= r_wdCount + 1'b1;
            else                   r_wdCount <= '0;
            if (w_timeout) r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state             <= S_IDLE;
            r_grant             <= G_SCAN;
            r_rrWrite           <= 1'b0;
            o_vram_address      <= '0;
            o_vram_write_data   <= '0;
            o_vram_write_enable <= 1'b0;
            o_vram_request      <= 1'b0;
            o_busy              <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyRequest) begin
                        r_grant             <= w_pick;
                        o_vram_address      <= w_pickAddress;
                        o_vram_write_enable <= (w_pick == G_WRITE);
                        o_vram_write_data   <= (w_pick == G_WRITE) ? i_rend_write_data : '0;
                        o_vram_request      <= 1'b1;
                        o_busy              <= 1'b1;
                        r_state             <= S_BUSY;
                        if (w_pick != G_SCAN) r_rrWrite <= ~r_rrWrite;
                    end
                end
                S_BUSY: begin
                    if (w_finish) begin
                        o_vram_request <= 1'b0;
                        o_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a transaction-level model predicts grants and completion
// pulses, a negedge monitor compares them against the DUT.
module tb_vram_arbiter;
   localparam int AW = 20;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          i_reset;
   logic [AW-1:0] i_scan_read_address, i_rend_read_address, i_rend_write_address;
   logic          i_scan_read_request, i_rend_read_request, i_rend_write_request;
   logic [DW-1:0] i_rend_write_data, i_vram_read_data;
   logic          i_vram_read_data_valid, i_vram_write_done;
   logic [DW-1:0] o_scan_read_data, o_rend_read_data, o_vram_write_data;
   logic          o_scan_read_data_valid, o_rend_read_data_valid, o_rend_write_done;
   logic [AW-1:0] o_vram_address;
   logic          o_vram_write_enable, o_vram_request, o_busy, o_error;

   vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WATCHDOG_CYCLES(255)) dut (
      .i_master_clk(clk), .i_reset(i_reset),
      .i_scan_read_address(i_scan_read_address), .i_scan_read_request(i_scan_read_request),
      .o_scan_read_data(o_scan_read_data), .o_scan_read_data_valid(o_scan_read_data_valid),
      .i_rend_read_address(i_rend_read_address), .i_rend_read_request(i_rend_read_request),
      .o_rend_read_data(o_rend_read_data), .o_rend_read_data_valid(o_rend_read_data_valid),
      .i_rend_write_address(i_rend_write_address), .i_rend_write_data(i_rend_write_data),
      .i_rend_write_request(i_rend_write_request), .o_rend_write_done(o_rend_write_done),
      .o_vram_address(o_vram_address), .o_vram_write_data(o_vram_write_data),
      .o_vram_write_enable(o_vram_write_enable), .o_vram_request(o_vram_request),
      .i_vram_read_data(i_vram_read_data), .i_vram_read_data_valid(i_vram_read_data_valid),
      .i_vram_write_done(i_vram_write_done), .o_busy(o_busy), .o_error(o_error)
   );

   always #5 clk = ~clk;

   // Requester ids: 0 scanout, 1 renderer read, 2 renderer write.
   typedef struct {
      int            cyc;
      int            who;
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] data;
   } exp_t;

   exp_t grantQ[$];
   exp_t cmplQ[$];
   int   checks = 0;
   int   passes = 0;
   int   cycleNum = 0;
   bit   monEn = 1'b0;
   bit   prevBusy = 1'b0;

   bit            pend[3];
   logic [AW-1:0] reqAddr[3];
   logic [DW-1:0] reqData;
   bit            mBusy, rrWrite, grantNext, cmplNext;
   int            winner, busyCnt, latency;

   always @(posedge clk) cycleNum <= cycleNum + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual === required) passes++;
      else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
   endtask

   // Scanout first, then whichever renderer the alternation pointer prefers, then the other one.
   function automatic int pickWinner();
      int pref;
      if (pend[0]) return 0;
      pref = rrWrite ? 2 : 1;
      if (pend[pref]) return pref;
      if (pend[3 - pref]) return 3 - pref;
      return -1;
   endfunction

   // mode 0 random traffic, 1 all three at once, 2 renderers continuous, 3 fixed write, 4 drain.
   task automatic applyStimulus(input int nCycles, input int mode);
      for (int c = 0; c < nCycles; c++) begin
         @(posedge clk); #1;
         if (cmplNext) begin mBusy = 1'b0; pend[winner] = 1'b0; cmplNext = 1'b0; end
         if (grantNext) begin
            mBusy = 1'b1; busyCnt = 0; grantNext = 1'b0;
            latency = (mode == 3) ? 3 : int'($urandom_range(1, 4));
         end
         for (int i = 0; i < 3; i++) begin
            bit raise;
            case (mode)
               0:       raise = ($urandom_range(0, 3) == 0);
               1:       raise = (c == 0);
               2:       raise = (i != 0);
               3:       raise = (i == 2);
               default: raise = 1'b0;
            endcase
            if (!pend[i] && raise) begin
               pend[i]    = 1'b1;
               reqAddr[i] = (mode == 3) ? 20'h12345 : AW'($urandom);
               if (i == 2) reqData = (mode == 3) ? 24'h00ABCD : DW'($urandom);
            end
         end
         i_scan_read_request  = pend[0]; i_scan_read_address  = reqAddr[0];
         i_rend_read_request  = pend[1]; i_rend_read_address  = reqAddr[1];
         i_rend_write_request = pend[2]; i_rend_write_address = reqAddr[2];
         i_rend_write_data    = reqData;
         i_vram_read_data_valid = 1'b0;
         i_vram_write_done      = 1'b0;
         i_vram_read_data       = DW'($urandom);
         if (mBusy) begin
            busyCnt++;
            if (busyCnt == latency) begin
               if ($urandom_range(0, 3) == 0) i_vram_read_data = '1;
               if (winner == 2) i_vram_write_done = 1'b1;
               else             i_vram_read_data_valid = 1'b1;
               cmplQ.push_back('{cycleNum, winner, reqAddr[winner], winner == 2, i_vram_read_data});
               cmplNext = 1'b1;
            end else if (mode == 0 && $urandom_range(0, 3) == 0) begin
               if (winner == 2) i_vram_read_data_valid = 1'b1;
               else             i_vram_write_done = 1'b1;
            end
         end else begin
            int w = pickWinner();
            if (mode == 0 && $urandom_range(0, 7) == 0) begin
               i_vram_read_data_valid = 1'($urandom_range(0, 1));
               i_vram_write_done      = !i_vram_read_data_valid;
            end
            if (w >= 0) begin
               winner    = w;
               grantNext = 1'b1;
               if (w != 0) rrWrite = !rrWrite;
               grantQ.push_back('{cycleNum + 1, w, reqAddr[w], w == 2, (w == 2) ? reqData : '0});
            end
         end
      end
   endtask

   task automatic drainModel();
      int budget = 0;
      while ((mBusy || grantNext || cmplNext || pend[0] || pend[1] || pend[2]) && budget < 100) begin
         applyStimulus(1, 4);
         budget++;
      end
      checkOutput("drain_idle", {o_busy, o_vram_request}, 2'b00);
   endtask

   // Monitor: grant timing/fields and completion routing compared every cycle against the queues.
   always @(negedge clk) begin
      if (monEn) begin
         exp_t e;
         bit   expG;
         expG = (grantQ.size() > 0) && (grantQ[0].cyc == cycleNum);
         checkOutput("grant_edge", o_busy && !prevBusy, expG);
         checkOutput("busy_level", o_busy, mBusy);
         if (expG) begin
            e = grantQ.pop_front();
            checkOutput("grant_req", o_vram_request, 1);
            checkOutput("grant_addr", o_vram_address, e.addr);
            checkOutput("grant_we", o_vram_write_enable, e.we);
            if (e.we) checkOutput("grant_wdata", o_vram_write_data, e.data);
         end
         if ((cmplQ.size() > 0) && (cmplQ[0].cyc == cycleNum)) begin
            e = cmplQ.pop_front();
            checkOutput("pulses", {o_scan_read_data_valid, o_rend_read_data_valid, o_rend_write_done},
                        3'b100 >> e.who);
            if (e.who == 0) checkOutput("scan_rdata", o_scan_read_data, e.data);
            if (e.who == 1) checkOutput("rend_rdata", o_rend_read_data, e.data);
         end else begin
            checkOutput("pulses_idle", {o_scan_read_data_valid, o_rend_read_data_valid, o_rend_write_done}, 0);
         end
      end
      prevBusy = o_busy;
   end

   initial begin
      i_reset = 1'b1;
      i_scan_read_address = '0; i_rend_read_address = '0; i_rend_write_address = '0;
      i_scan_read_request = 1'b0; i_rend_read_request = 1'b0; i_rend_write_request = 1'b0;
      i_rend_write_data = '0; i_vram_read_data = '0;
      i_vram_read_data_valid = 1'b0; i_vram_write_done = 1'b0;
      pend = '{1'b0, 1'b0, 1'b0}; reqAddr = '{'0, '0, '0}; reqData = '0;
      mBusy = 1'b0; rrWrite = 1'b0; grantNext = 1'b0; cmplNext = 1'b0;
      winner = 0; busyCnt = 0; latency = 1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", {o_vram_request, o_busy, o_error, o_vram_write_enable, o_vram_address,
                  o_vram_write_data, o_scan_read_data_valid, o_rend_read_data_valid, o_rend_write_done}, 0);
      @(negedge clk);
      i_reset = 1'b0;
      monEn = 1'b1;

      applyStimulus(20, 1);
      applyStimulus(40, 2);
      applyStimulus(12, 3);
      applyStimulus(400, 0);
      drainModel();

      monEn = 1'b0;
      i_rend_write_request = 1'b1; i_rend_write_address = 20'h0BEEF; i_rend_write_data = 24'h123456;
      @(posedge clk); #1;
      checkOutput("rst_pre_busy", o_busy, 1);
      i_vram_write_done = 1'b1;
      #1;
      checkOutput("rst_pre_pulse", o_rend_write_done, 1);
      i_reset = 1'b1;
      #1;
      checkOutput("rst_mid_busy", {o_vram_request, o_busy, o_scan_read_data_valid,
                  o_rend_read_data_valid, o_rend_write_done}, 0);
      i_vram_write_done = 1'b0; i_rend_write_request = 1'b0;
      pend = '{1'b0, 1'b0, 1'b0};
      mBusy = 1'b0; rrWrite = 1'b0; grantNext = 1'b0; cmplNext = 1'b0;
      grantQ.delete(); cmplQ.delete();
      @(negedge clk);
      i_reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_after_idle", {o_busy, o_vram_request}, 0);
      monEn = 1'b1;

      applyStimulus(30, 2);
      drainModel();
      @(negedge clk); #1;
      checkOutput("queues_empty", grantQ.size() + cmplQ.size(), 0);
      checkOutput("error_low", o_error, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
